triangle_feeder: RTL and testbench

TRIANGLE_FEEDER -- requirements
Module: triangle_feeder

---
 rtl/triangle_feeder.sv | 199 +++++++++++++++++++
 tb/tb_triangle_feeder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_feeder.sv
// Triangle feeder: queues vertices and issues them three at a time to a
// rendering engine, then buffers the engine's pixel stream for a consumer.
module triangle_feeder #(
   parameter int VDEPTH = 6,
   parameter int PDEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_valid,
   input  logic [5:0] ld_data,
   output logic       ld_ready,
   output logic       nt,
   output logic [2:0] xi,
   output logic [2:0] yi,
   input  logic       busy,
   input  logic       po,
   input  logic [2:0] xo,
   input  logic [2:0] yo,
   output logic       pix_valid,
   output logic [5:0] pix_data,
   input  logic       pix_ready,
   output logic       ovf,
   output logic [7:0] tri_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SEND1 = 3'd1;
   localparam logic [2:0] S_SEND2 = 3'd2;
   localparam logic [2:0] S_SEND3 = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   localparam int VPW = (VDEPTH > 1) ? $clog2(VDEPTH) : 1;
   localparam int VCW = $clog2(VDEPTH + 1);
   localparam int PPW = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;
   localparam int PCW = $clog2(PDEPTH + 1);

   localparam logic [VPW-1:0] VLAST = VPW'(VDEPTH - 1);
   localparam logic [VCW-1:0] VFULL = VCW'(VDEPTH);
   localparam logic [PCW-1:0] PFULL = PCW'(PDEPTH);

   logic [2:0]     state_r;
   logic [2:0]     state_nxt_s;
   logic           nt_nxt_s;
   logic [5:0]     v_next_s;

   logic [5:0]     vmem_r [VDEPTH];
   logic [VPW-1:0] v_wr_r;
   logic [VPW-1:0] v_rd_r;
   logic [VCW-1:0] v_cnt_r;
   logic           v_push_s;
   logic           v_pop_s;

   logic [5:0]     pmem_r [PDEPTH];
   logic [PPW-1:0] p_wr_r;
   logic [PPW-1:0] p_rd_r;
   logic [PCW-1:0] p_cnt_r;
   logic           p_push_s;
   logic           p_pop_s;
   logic           p_full_s;

   // Vertex depth need not be a power of two, so the pointer wraps explicitly.
   function automatic logic [VPW-1:0] vptr_inc(input logic [VPW-1:0] p);
      logic [VPW-1:0] r;
      if (p == VLAST) begin
         r = {VPW{1'b0}};
      end else begin
         r = p + VPW'(1);
      end
      return r;
   endfunction

   assign ld_ready  = (v_cnt_r < VFULL);
   assign v_push_s  = ld_valid & ld_ready;

   assign pix_valid = (p_cnt_r != {PCW{1'b0}});
   assign pix_data  = pmem_r[p_rd_r];
   assign p_full_s  = (p_cnt_r == PFULL);
   assign p_pop_s   = pix_valid & pix_ready;
   assign p_push_s  = po & (~p_full_s | p_pop_s);

   // Next state plus the vertex the engine sees next cycle (a pop lands at the same edge)
   always_comb begin
      state_nxt_s = state_r;
      nt_nxt_s    = 1'b0;
      v_next_s    = 6'd0;
      v_pop_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if ((v_cnt_r >= VCW'(3)) && !busy) begin
               state_nxt_s = S_SEND1;
               nt_nxt_s    = 1'b1;
               v_next_s    = vmem_r[v_rd_r];
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_SEND1: begin
            state_nxt_s = S_SEND2;
            v_pop_s     = 1'b1;
            v_next_s    = vmem_r[vptr_inc(v_rd_r)];
         end
         S_SEND2: begin
            state_nxt_s = S_SEND3;
            v_pop_s     = 1'b1;
            v_next_s    = vmem_r[vptr_inc(v_rd_r)];
         end
         S_SEND3: begin
            state_nxt_s = S_HOLD;
            v_pop_s     = 1'b1;
         end
         S_HOLD: begin
            state_nxt_s = S_WAIT;
         end
         S_WAIT: begin
            if (busy) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register, engine-facing outputs and triangle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         nt      <= 1'b0;
         xi      <= 3'd0;
         yi      <= 3'd0;
         tri_cnt <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         nt      <= nt_nxt_s;
         xi      <= v_next_s[5:3];
         yi      <= v_next_s[2:0];
         if (state_r == S_SEND1) begin
            tri_cnt <= tri_cnt + 8'd1;
         end
      end
   end

   // Vertex FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         v_wr_r  <= {VPW{1'b0}};
         v_rd_r  <= {VPW{1'b0}};
         v_cnt_r <= {VCW{1'b0}};
      end else begin
         if (v_push_s) begin
            v_wr_r <= vptr_inc(v_wr_r);
         end
         if (v_pop_s) begin
            v_rd_r <= vptr_inc(v_rd_r);
         end
         v_cnt_r <= v_cnt_r + VCW'(v_push_s) - VCW'(v_pop_s);
      end
   end

   // Vertex storage
   always_ff @(posedge clk) begin
      if (!reset && v_push_s) begin
         vmem_r[v_wr_r] <= ld_data;
      end
   end

   // Pixel FIFO pointers, occupancy and sticky drop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         p_wr_r  <= {PPW{1'b0}};
         p_rd_r  <= {PPW{1'b0}};
         p_cnt_r <= {PCW{1'b0}};
         ovf     <= 1'b0;
      end else begin
         if (p_push_s) begin
            p_wr_r <= p_wr_r + PPW'(1);
         end
         if (p_pop_s) begin
            p_rd_r <= p_rd_r + PPW'(1);
         end
         p_cnt_r <= p_cnt_r + PCW'(p_push_s) - PCW'(p_pop_s);
         if (po && p_full_s && !p_pop_s) begin
            ovf <= 1'b1;
         end
      end
   end

   // Pixel storage
   always_ff @(posedge clk) begin
      if (!reset && p_push_s) begin
         pmem_r[p_wr_r] <= {xo, yo};
      end
   end

endmodule

// File: tb/tb_triangle_feeder.sv
// Bench for triangle_feeder: directed timing scenarios plus a long random run,
// with a queue-based reference model checked on every falling edge.
module tb_triangle_feeder;

   localparam int VDEPTH = 6;
   localparam int PDEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ld_valid = 1'b0;
   logic [5:0] ld_data = 6'd0;
   logic       ld_ready;
   logic       nt;
   logic [2:0] xi;
   logic [2:0] yi;
   logic       busy = 1'b0;
   logic       po = 1'b0;
   logic [2:0] xo = 3'd0;
   logic [2:0] yo = 3'd0;
   logic       pix_valid;
   logic [5:0] pix_data;
   logic       pix_ready = 1'b0;
   logic       ovf;
   logic [7:0] tri_cnt;

   triangle_feeder #(.VDEPTH(VDEPTH), .PDEPTH(PDEPTH)) dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .nt(nt), .xi(xi), .yi(yi), .busy(busy), .po(po),
      .xo(xo), .yo(yo), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(pix_ready), .ovf(ovf), .tri_cnt(tri_cnt)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail = 0;

   // Scoreboard: accepted vertices in order, issued three per triangle
   logic [5:0] exp_vtx[$];
   // Reference model state owned by the monitor
   int         phase = 0;
   int         gap = 99;
   int         vcount_m = 0;
   logic [7:0] tri_m = 8'd0;
   logic       ovf_m = 1'b0;
   logic       busy_prev = 1'b0;
   logic [5:0] pq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares outputs against the model away from the active edge
   initial begin
      logic       vout;
      logic [5:0] v;
      forever begin
         @(negedge clk);
         vout = 1'b0;
         if (reset) begin
            phase = 0; gap = 99; vcount_m = 0; tri_m = 8'd0; ovf_m = 1'b0;
            pq.delete();
         end else begin
            if (phase == 0) begin
               if (nt) begin
                  check("nt_busy_low", 32'(busy_prev), 32'd0);
                  check("nt_gap", 32'(gap >= 3), 32'd1);
                  check("tri_avail", 32'(exp_vtx.size() >= 3), 32'd1);
                  v = 6'd0;
                  if (exp_vtx.size() > 0) v = exp_vtx.pop_front();
                  check("vtx1", 32'({xi, yi}), 32'(v));
                  check("cnt_send1", 32'(tri_cnt), 32'(tri_m));
                  tri_m = tri_m + 8'd1;
                  phase = 1;
                  vout = 1'b1;
               end else begin
                  check("idle_xy", 32'({xi, yi}), 32'd0);
                  check("cnt_idle", 32'(tri_cnt), 32'(tri_m));
                  if (gap < 1000) gap++;
               end
            end else begin
               check("nt_low", 32'(nt), 32'd0);
               v = 6'd0;
               if (exp_vtx.size() > 0) v = exp_vtx.pop_front();
               check("vtx23", 32'({xi, yi}), 32'(v));
               check("cnt_send", 32'(tri_cnt), 32'(tri_m));
               vout = 1'b1;
               if (phase == 2) begin
                  phase = 0;
                  gap = 0;
               end else begin
                  phase = 2;
               end
            end
            check("ld_ready", 32'(ld_ready), 32'(vcount_m < VDEPTH));
            if (ld_valid && ld_ready) vcount_m++;
            if (vout) vcount_m--;
            check("pix_valid", 32'(pix_valid), 32'(pq.size() != 0));
            if (pq.size() != 0) check("pix_data", 32'(pix_data), 32'(pq[0]));
            check("ovf", 32'(ovf), 32'(ovf_m));
            if (pq.size() != 0 && pix_ready) void'(pq.pop_front());
            if (po) begin
               if (pq.size() < PDEPTH) pq.push_back({xo, yo});
               else ovf_m = 1'b1;
            end
         end
         busy_prev = busy;
      end
   end

   task automatic do_reset();
      reset = 1'b1; ld_valid = 1'b0; po = 1'b0; pix_ready = 1'b0; busy = 1'b0;
      exp_vtx.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_nt", 32'(nt), 32'd0);
      check("rst_xy", 32'({xi, yi}), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_tri_cnt", 32'(tri_cnt), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic push_vtx(input logic [5:0] d);
      ld_valid = 1'b1;
      ld_data  = d;
      if (ld_ready) exp_vtx.push_back(d);
      @(posedge clk); #1;
      ld_valid = 1'b0;
   endtask

   task automatic send_pix(input logic [5:0] d);
      po = 1'b1;
      {xo, yo} = d;
      @(posedge clk); #1;
      po = 1'b0;
   endtask

   task automatic wait_nt(input int limit);
      int k;
      k = 0;
      @(negedge clk);
      while (!nt && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("nt_seen", 32'(nt), 32'd1);
   endtask

   // Pops the pixel FIFO and checks it against dexp in order, then expects empty
   logic [5:0] dexp[$];
   task automatic drain_pix();
      @(posedge clk); #1 pix_ready = 1'b1;
      for (int i = 0; i < dexp.size(); i++) begin
         @(negedge clk);
         check("pix_order", 32'(pix_data), 32'(dexp[i]));
      end
      @(negedge clk);
      check("pix_drained", 32'(pix_valid), 32'd0);
      @(posedge clk); #1 pix_ready = 1'b0;
   endtask

   initial begin
      int         acc;
      int         cyc;
      logic [5:0] d0;

      do_reset();

      // First triangle: exact issue timing and vertex order
      push_vtx(6'b010_011); push_vtx(6'b110_001); push_vtx(6'b000_111);
      @(negedge clk); check("t1_pre_nt", 32'(nt), 32'd0);
      @(negedge clk); check("t1_nt", 32'(nt), 32'd1);
      check("t1_v1", 32'({xi, yi}), 32'(6'b010_011));
      @(negedge clk); check("t1_v2", 32'({nt, xi, yi}), 32'({1'b0, 6'b110_001}));
      @(negedge clk); check("t1_v3", 32'({nt, xi, yi}), 32'({1'b0, 6'b000_111}));
      check("t1_cnt", 32'(tri_cnt), 32'd1);
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;

      // Second triangle held off while the engine is busy
      do_reset();
      for (int i = 0; i < 6; i++) push_vtx(6'($urandom));
      busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); check("t2_hold_nt", 32'(nt), 32'd0);
      end
      check("t2_cnt_hold", 32'(tri_cnt), 32'd1);
      @(posedge clk); #1 busy = 1'b0;
      @(negedge clk); check("t2_wait_nt", 32'(nt), 32'd0);
      @(negedge clk); check("t2_idle_nt", 32'(nt), 32'd0);
      @(negedge clk); check("t2_send_nt", 32'(nt), 32'd1);
      @(negedge clk); check("t2_cnt", 32'(tri_cnt), 32'd2);
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;

      // Pixel overflow: nine pushes into eight slots, first eight kept
      do_reset();
      dexp.delete();
      for (int i = 0; i < 9; i++) begin
         d0 = 6'(i * 5 + 3);
         if (i < 8) dexp.push_back(d0);
         send_pix(d0);
      end
      @(negedge clk);
      check("t3_valid", 32'(pix_valid), 32'd1);
      check("t3_ovf", 32'(ovf), 32'd1);
      drain_pix();
      check("t3_ovf_sticky", 32'(ovf), 32'd1);

      // Full FIFO with simultaneous push and pop: no drop
      do_reset();
      dexp.delete();
      for (int i = 0; i < 8; i++) begin
         d0 = 6'(60 - i * 3);
         if (i > 0) dexp.push_back(d0);
         send_pix(d0);
      end
      po = 1'b1; {xo, yo} = 6'd7; pix_ready = 1'b1;
      dexp.push_back(6'd7);
      @(posedge clk); #1 po = 1'b0; pix_ready = 1'b0;
      @(negedge clk);
      check("t4_ovf", 32'(ovf), 32'd0);
      check("t4_valid", 32'(pix_valid), 32'd1);
      drain_pix();
      check("t4_ovf_end", 32'(ovf), 32'd0);

      // Reset during SEND2 discards the partial triangle
      do_reset();
      for (int i = 0; i < 3; i++) push_vtx(6'($urandom));
      wait_nt(10);
      @(posedge clk); #1;
      reset = 1'b1; ld_valid = 1'b0; exp_vtx.delete();
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("t5_nt", 32'(nt), 32'd0);
      check("t5_xy", 32'({xi, yi}), 32'd0);
      check("t5_cnt", 32'(tri_cnt), 32'd0);
      check("t5_ready", 32'(ld_ready), 32'd1);
      @(posedge clk); #1;
      d0 = 6'($urandom);
      push_vtx(d0); push_vtx(6'($urandom)); push_vtx(6'($urandom));
      wait_nt(10);
      check("t5_fresh", 32'({xi, yi}), 32'(d0));
      @(posedge clk); #1;
      repeat (6) @(posedge clk);
      #1;

      // Random run: 256 triangles under random busy and pixel traffic
      do_reset();
      acc = 0;
      cyc = 0;
      while (acc < 768 && cyc < 20000) begin
         ld_valid  = ($urandom_range(3, 0) != 0);
         ld_data   = 6'($urandom);
         busy      = ($urandom_range(9, 0) < 3);
         po        = 1'($urandom_range(1, 0));
         xo        = 3'($urandom);
         yo        = 3'($urandom);
         pix_ready = ($urandom_range(9, 0) < 4);
         if (ld_valid && ld_ready) begin
            exp_vtx.push_back(ld_data);
            acc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("t6_loaded", 32'(acc), 32'd768);
      ld_valid = 1'b0; busy = 1'b0; po = 1'b0;
      cyc = 0;
      while ((exp_vtx.size() != 0 || phase != 0) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("t6_drained", 32'(exp_vtx.size()), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_wrap", 32'(tri_cnt), 32'd0);
      @(posedge clk); #1 pix_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t6_pix_empty", 32'(pix_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
